lr_shift_pipe: RTL and testbench
================================

Name: lr_shift_pipe

Overview:
Parametrised, pipelined successor to the generic combinational left shifter. Supports logical left, logical right and arithmetic right shifts, plus an optional rotate-left mode, on a WIDTH-bit operand. Built as a log2 barrel shifter split across REG_STAGES register stages, with valid/ready handshakes on input and output. Sits between datapath producers and consumers that need a timing-closed shifter with backpressure.

Parameters:
WIDTH, 32, operand/result width in bits; any value >= 2, not required to be a power of two.
REG_STAGES, 2, number of pipeline register stages; legal range 1..LEVELS, where LEVELS = clog2(WIDTH).

Ports:
clk  input  1  clock
rst  input  1  reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept the input beat this cycle
in_bits  input  WIDTH  operand
in_shift  input  clog2(WIDTH)  shift amount, unsigned
in_mode  input  2  0=LSL, 1=LSR, 2=ASR, 3=ROL
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_bits  output  WIDTH  result

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset effects: all stage valid flags clear, so out_valid=0. Stage data registers are don't-care, but out_bits drives 0 after reset until the first result. in_ready=1 in the cycle after reset deasserts.
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv, combinational.
  - A beat is accepted when in_valid && in_ready.
  - When adv=1 every stage loads from its predecessor, and stage 0 loads {in_valid, bits, shift, mode}. Bubbles propagate as valid=0 and are not collapsed.
  - When adv=0 all stages hold.
- Latency: exactly REG_STAGES cycles from acceptance to out_valid, given no stall. Throughput is 1 beat per cycle. Results leave strictly in order, with no loss or duplication.
- Levels: k = 0..LEVELS-1. Level k shifts by 2^k in the current mode when shift bit k is 1, and passes the data through otherwise.
  - Levels are grouped into stages in ascending order. Stage s holds levels [s*C, min((s+1)*C, LEVELS)), where C = ceil(LEVELS/REG_STAGES).
  - Mode and the unused shift bits are carried alongside the data through every stage.
- Mode semantics:
  - LSL: shifts left, zero fill.
  - LSR: shifts right, zero fill.
  - ASR: shifts right, filling with a copy of operand bit WIDTH-1.
  - ROL: rotates left.
- Shift amount >= WIDTH (only possible for non-power-of-two WIDTH):
  - LSL/LSR give all zeros.
  - ASR gives all copies of the sign bit.
  - ROL rotates by (shift mod WIDTH).
  - The implementation must handle this explicitly and must not rely on the raw level cascade.
- Shift 0 in any mode: out_bits = in_bits.
- Stall while full: all data is held stable. out_bits and out_valid must not change while out_valid=1 and out_ready=0.
- Reset asserted mid-operation: all in-flight beats are discarded. out_valid=0 on the next cycle. A beat presented during the reset cycle is not accepted.

Optional Feature:
Macro: LRSHIFT_ROTATE_EN.
- Defined: in_mode=3 performs rotate-left, as specified above.
- Undefined: rotate logic is omitted and in_mode=3 is decoded exactly as LSL. The port width is unchanged.

Decomposition:
- Package lr_shift_pkg contains:
  - enum shift_mode_t (LSL=0, LSR=1, ASR=2, ROL=3);
  - function levels(width) = clog2(width);
  - function levels_per_stage(width, reg_stages).
- One sub-module, shift_level: a combinational single level.
  - Parameters WIDTH and K.
  - Inputs are data, enable bit and mode; output is data.
  - It applies a 2^K shift, with rotate gated by LRSHIFT_ROTATE_EN.
  - lr_shift_pipe instantiates LEVELS copies of it, with registers placed between groups.

Test Plan:
1. WIDTH=8, REG_STAGES=2. Inputs 0x81, shift 1, LSL, out_ready=1 -> out_valid exactly 2 cycles after acceptance, out_bits=0x02.
2. WIDTH=8. Input 0x90, shift 3: ASR -> 0xF2; LSR -> 0x12. Shift 0 in any mode -> 0x90.
3. WIDTH=8. Input 0x81, shift 1, mode 3 -> 0x03 with LRSHIFT_ROTATE_EN defined, 0x02 without it.
4. Backpressure: 4 back-to-back beats (0x01, 0x02, 0x04, 0x08, shift 1, LSL), then out_ready=0 for 5 cycles -> in_ready drops once out_valid=1 and stalls. Outputs 0x02, 0x04, 0x08, 0x10 appear in order with no duplicate; out_bits is stable while stalled.
5. WIDTH=6, REG_STAGES=3. Input 0x21 with shift 7: LSR -> 0x00; ASR -> 0x3F; ROL (macro on) -> 0x03.
6. Two beats in flight, rst=1 for 1 cycle -> out_valid=0 the next cycle, both beats never emerge, and in_ready=1 once rst=0.

Source files
------------

// File: rtl/lr_shift_pkg.sv
// Shared types and sizing helpers for the pipelined barrel shifter.
// Latency: n/a (package only).
// Backpressure: n/a. Optional rotate mode is controlled by LRSHIFT_ROTATE_EN.
package lr_shift_pkg;

  typedef enum logic [1:0] {
    LSL = 2'd0,
    LSR = 2'd1,
    ASR = 2'd2,
    ROL = 2'd3
  } shift_mode_t;

  // Number of barrel levels needed to cover every shift amount of a width.
  function automatic int levels(input int width);
    return $clog2(width);
  endfunction

  // Levels packed into each register stage (ceiling division).
  function automatic int levels_per_stage(input int width, input int reg_stages);
    return (levels(width) + reg_stages - 1) / reg_stages;
  endfunction

endpackage

// File: rtl/lr_shift_pipe_level.sv
// One combinational barrel level: shifts by 2^K in the selected mode when enabled.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; rotate is built only when LRSHIFT_ROTATE_EN is defined.
module shift_level
  import lr_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en_i,
  input  shift_mode_t      mode_i,
  output logic [WIDTH-1:0] data_o
);

  // 2^K is always below WIDTH because K < clog2(WIDTH).
  localparam int AMT = 1 << K;

  // Apply this level's fixed shift, or pass the data through.
  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (mode_i)
        LSR:     data_o = data_i >> AMT;
        ASR:     data_o = $signed(data_i) >>> AMT;
`ifdef LRSHIFT_ROTATE_EN
        ROL:     data_o = (data_i << AMT) | (data_i >> (WIDTH - AMT));
`endif
        default: data_o = data_i << AMT;
      endcase
    end
  end

endmodule

// File: rtl/lr_shift_pipe.sv
// Pipelined LSL/LSR/ASR(/ROL with LRSHIFT_ROTATE_EN) barrel shifter, levels grouped into stages.
// Latency: REG_STAGES cycles from acceptance to out_valid; one beat per cycle.
// Backpressure: whole pipe advances together; in_ready = !out_valid || out_ready.
module lr_shift_pipe
  import lr_shift_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_bits,
  input  logic [levels(WIDTH)-1:0]  in_shift,
  input  logic [1:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_bits
);

  localparam int LEVELS = levels(WIDTH);
  localparam int C      = levels_per_stage(WIDTH, REG_STAGES);
  localparam logic [LEVELS:0] W_EXT = (LEVELS+1)'(WIDTH);

  logic              adv;
  logic [WIDTH-1:0]  pre_data;
  logic [LEVELS-1:0] pre_shift;
  shift_mode_t       pre_mode;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Normalise the request: fold mode 3 when rotate is absent, and resolve
  // shift >= WIDTH up front so the level cascade never sees it.
  always_comb begin
    pre_data  = in_bits;
    pre_shift = in_shift;
    pre_mode  = shift_mode_t'(in_mode);
`ifndef LRSHIFT_ROTATE_EN
    if (pre_mode == ROL) pre_mode = LSL;
`endif
    if ({1'b0, in_shift} >= W_EXT) begin
      case (pre_mode)
        ROL: pre_shift = LEVELS'({1'b0, in_shift} - W_EXT);
        ASR: begin
          pre_data  = {WIDTH{in_bits[WIDTH-1]}};
          pre_shift = '0;
        end
        default: begin
          pre_data  = '0;
          pre_shift = '0;
        end
      endcase
    end
  end

  for (genvar s = 0; s < REG_STAGES; s++) begin : g_stg
    localparam int LO = s * C;
    localparam int HI = ((s + 1) * C < LEVELS) ? (s + 1) * C : LEVELS;

    logic              vld_d;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  data_d;
    logic [LEVELS-1:0] shift_d;
    shift_mode_t       mode_d;
    logic              vld_q;
    logic [WIDTH-1:0]  data_q;
    logic              unused_bits;

    // Shift bits already consumed by earlier stages are carried but ignored.
    assign unused_bits = ^{shift_d, mode_d};

    if (s == 0) begin : g_src
      assign vld_d   = in_valid;
      assign data_in = pre_data;
      assign shift_d = pre_shift;
      assign mode_d  = pre_mode;
    end else begin : g_src
      assign vld_d   = g_stg[s-1].vld_q;
      assign data_in = g_stg[s-1].data_q;
      assign shift_d = g_stg[s-1].g_ctl.shift_q;
      assign mode_d  = g_stg[s-1].g_ctl.mode_q;
    end

    for (genvar j = 0; j < C; j++) begin : g_lvl
      if (LO + j < LEVELS) begin : g_on
        logic [WIDTH-1:0] lin;
        logic [WIDTH-1:0] lout;
        if (j == 0) begin : g_first
          assign lin = data_in;
        end else begin : g_chain
          assign lin = g_lvl[j-1].g_on.lout;
        end
        shift_level #(.WIDTH(WIDTH), .K(LO + j)) u_lvl (
          .data_i (lin),
          .en_i   (shift_d[LO+j]),
          .mode_i (mode_d),
          .data_o (lout)
        );
      end
    end

    // A stage left with no levels simply forwards its input.
    if (HI > LO) begin : g_out
      assign data_d = g_lvl[HI-LO-1].g_on.lout;
    end else begin : g_out
      assign data_d = data_in;
    end

    // Stage register: valid is reset, data only loads on advance.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
      end else if (adv) begin
        vld_q  <= vld_d;
        data_q <= data_d;
      end
    end

    // Control for later stages; the last stage has no consumer for it.
    if (s < REG_STAGES - 1) begin : g_ctl
      logic [LEVELS-1:0] shift_q;
      shift_mode_t       mode_q;
      // Carry mode and shift amount alongside the data.
      always_ff @(posedge clk) begin
        if (adv) begin
          shift_q <= shift_d;
          mode_q  <= mode_d;
        end
      end
    end
  end

  assign out_valid = g_stg[REG_STAGES-1].vld_q;
  assign out_bits  = out_valid ? g_stg[REG_STAGES-1].data_q : '0;

endmodule

// File: tb/tb_lr_shift_pipe.sv
module tb_lr_shift_pipe;

`ifdef LRSHIFT_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       vld    [2];
  logic       ordy   [2];
  logic [7:0] bits   [2];
  logic [2:0] sh     [2];
  logic [1:0] md     [2];
  logic [7:0] lit    [2];
  bit         haslit [2];

  logic       rdy8, rdy6, ov8, ov6;
  logic [7:0] ob8;
  logic [5:0] ob6;

  lr_shift_pipe #(.WIDTH(8), .REG_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy8), .in_bits(bits[0]),
    .in_shift(sh[0]), .in_mode(md[0]), .out_valid(ov8), .out_ready(ordy[0]), .out_bits(ob8));

  lr_shift_pipe #(.WIDTH(6), .REG_STAGES(3)) dut6 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy6), .in_bits(bits[1][5:0]),
    .in_shift(sh[1]), .in_mode(md[1]), .out_valid(ov6), .out_ready(ordy[1]), .out_bits(ob6));

  // Reference result straight from the mode definitions.
  function automatic logic [7:0] model(input int w, input logic [7:0] x, input int s, input int m);
    int unsigned mask, v, r, a;
    mask = (32'd1 << w) - 1;
    v = {24'd0, x} & mask;
    if (m == 3 && !ROT) m = 0;
    case (m)
      0: r = (s >= w) ? 0 : ((v << s) & mask);
      1: r = (s >= w) ? 0 : (v >> s);
      2: r = ((v >> (w - 1)) & 1) != 0 ? (~((~v & mask) >> s)) & mask : (v >> s);
      default: begin
        a = s % w;
        r = ((v << a) | (v >> (w - a))) & mask;
      end
    endcase
    return r[7:0];
  endfunction

  typedef struct {
    logic [7:0] exp;
    logic [7:0] lit;
    bit         has_lit;
    int         acc;
    int         st0;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         stalls [2];
  int         waitc  [2];
  bit         rst_seen [2];
  bit         prev_stall [2];
  bit         fresh [2];
  logic [7:0] prev_ob [2];
  bit         end_req = 1'b0;
  bit         end_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic do_dut(input int d);
    ent_t e;
    logic o, r, orr;
    logic [7:0] ob;
    int w, rs, qs;
    orr = ordy[d];
    if (d == 0) begin r = rdy8; o = ov8; ob = ob8; w = 8; rs = 2; qs = q0.size(); end
    else begin r = rdy6; o = ov6; ob = {2'b00, ob6}; w = 6; rs = 3; qs = q1.size(); end

    if (rst) begin
      if (d == 0) q0.delete(); else q1.delete();
      rst_seen[d] = 1'b1;
      prev_stall[d] = 1'b0;
      fresh[d] = 1'b1;
      waitc[d] = 0;
      return;
    end

    if (rst_seen[d]) begin
      chk($sformatf("d%0d out_valid after reset", d), o, 0);
      rst_seen[d] = 1'b0;
    end
    chk($sformatf("d%0d in_ready", d), r, !o || orr);
    if (prev_stall[d]) begin
      chk($sformatf("d%0d stall out_valid held", d), o, 1);
      chk($sformatf("d%0d stall out_bits held", d), ob, prev_ob[d]);
    end
    if (!o && fresh[d]) chk($sformatf("d%0d out_bits zero before first result", d), ob, 0);

    if (o) begin
      fresh[d] = 1'b0;
      chk($sformatf("d%0d beat pending at out_valid", d), qs != 0, 1);
      if (qs != 0) begin
        e = (d == 0) ? q0[0] : q1[0];
        chk($sformatf("d%0d result", d), ob, e.exp);
        if (e.has_lit) chk($sformatf("d%0d literal result", d), ob, e.lit);
        if (orr) begin
          chk($sformatf("d%0d latency", d), cyc, e.acc + rs + (stalls[d] - e.st0));
          if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
    end
    if (o && !orr) stalls[d]++;
    prev_stall[d] = o && !orr;
    prev_ob[d] = ob;

    if (vld[d]) begin
      if (!r) waitc[d]++; else waitc[d] = 0;
      chk($sformatf("d%0d input wait bounded", d), waitc[d] <= 40, 1);
    end
    if (vld[d] && r) begin
      e.exp = model(w, bits[d], int'(sh[d]), int'(md[d]));
      e.lit = lit[d];
      e.has_lit = haslit[d];
      e.acc = cyc;
      e.st0 = stalls[d];
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  // Single compare process: checks both instances every cycle.
  always @(negedge clk) begin
    cyc++;
    if (cyc == 1) begin
      chk("pin lsl 81>>1", model(8, 8'h81, 1, 0), 8'h02);
      chk("pin asr 90/3", model(8, 8'h90, 3, 2), 8'hF2);
      chk("pin lsr 90/3", model(8, 8'h90, 3, 1), 8'h12);
      chk("pin mode3 81/1", model(8, 8'h81, 1, 3), ROT ? 8'h03 : 8'h02);
      chk("pin w6 asr sh7", model(6, 8'h21, 7, 2), 8'h3F);
      chk("pin w6 rol sh7", model(6, 8'h21, 7, 3), ROT ? 8'h03 : 8'h00);
    end
    do_dut(0);
    do_dut(1);
    if (end_req && !end_done) begin
      chk("all beats drained", q0.size() + q1.size(), 0);
      end_done = 1'b1;
    end
  end

  task automatic send(input int d, input logic [7:0] b, input int s, input int m,
                      input logic [7:0] l, input bit hl);
    bit ok;
    vld[d] = 1'b1; bits[d] = b; sh[d] = 3'(s); md[d] = 2'(m);
    lit[d] = l; haslit[d] = hl;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = (d == 0) ? rdy8 : rdy6;
    end
    @(posedge clk); #1;
    vld[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; ordy[d] = 1'b1; bits[d] = '0; sh[d] = '0; md[d] = '0;
      lit[d] = '0; haslit[d] = 1'b0; stalls[d] = 0; waitc[d] = 0;
      rst_seen[d] = 1'b0; prev_stall[d] = 1'b0; fresh[d] = 1'b1; prev_ob[d] = '0;
    end
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Basic LSL and latency
    send(0, 8'h81, 1, 0, 8'h02, 1);
    idle(4);
    // ASR / LSR / shift 0 in each mode, back to back
    send(0, 8'h90, 3, 2, 8'hF2, 1);
    send(0, 8'h90, 3, 1, 8'h12, 1);
    for (int m = 0; m < 4; m++) send(0, 8'h90, 0, m, 8'h90, 1);
    send(0, 8'h81, 1, 3, ROT ? 8'h03 : 8'h02, 1);
    send(0, 8'hF0, 7, 2, 8'hFF, 1);
    idle(4);

    // Backpressure: four beats with the consumer stalled
    ordy[0] = 1'b0;
    fork
      begin
        send(0, 8'h01, 1, 0, 8'h02, 1);
        send(0, 8'h02, 1, 0, 8'h04, 1);
        send(0, 8'h04, 1, 0, 8'h08, 1);
        send(0, 8'h08, 1, 0, 8'h10, 1);
      end
      begin
        idle(7);
        ordy[0] = 1'b1;
      end
    join
    idle(5);

    // Non-power-of-two width, shift beyond width
    send(1, 8'h21, 7, 1, 8'h00, 1);
    send(1, 8'h21, 7, 2, 8'h3F, 1);
    send(1, 8'h21, 7, 3, ROT ? 8'h03 : 8'h00, 1);
    send(1, 8'h21, 2, 3, ROT ? 8'h06 : 8'h04, 1);
    send(1, 8'h2C, 3, 2, 8'h3D, 1);
    send(1, 8'h21, 5, 0, 8'h20, 1);
    send(1, 8'h21, 6, 0, 8'h00, 1);
    ordy[1] = 1'b0;
    fork
      begin
        send(1, 8'h15, 1, 1, 8'h0A, 1);
        send(1, 8'h2A, 4, 2, 8'h3E, 1);
        send(1, 8'h33, 0, 3, 8'h33, 1);
        send(1, 8'h01, 5, 0, 8'h20, 1);
      end
      begin
        idle(8);
        ordy[1] = 1'b1;
      end
    join
    idle(6);

    // Reset with two beats in flight; a beat offered during reset must be dropped
    send(0, 8'h11, 1, 0, 8'h22, 1);
    send(0, 8'h22, 1, 0, 8'h44, 1);
    rst = 1'b1;
    vld[0] = 1'b1; bits[0] = 8'h55; sh[0] = 3'd1; md[0] = 2'd0; haslit[0] = 1'b0;
    idle(1);
    rst = 1'b0;
    vld[0] = 1'b0;
    idle(6);
    send(0, 8'h03, 2, 0, 8'h0C, 1);

    ordy[0] = 1'b1;
    ordy[1] = 1'b1;
    idle(20);
    end_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
